// File: rtl/pokemon_pkg.sv
// Shared types for the overworld character: facing direction, movement state,
// keyboard keycodes and tile geometry.
package pokemon_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        WALK = 2'd2
    } move_state_e;

    localparam logic [7:0] KEY_UP    = 8'h1A;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_LEFT  = 8'h04;

    localparam int TILE_PX = 16;

    typedef struct packed {
        logic valid;
        dir_e dir;
    } key_t;

    function automatic key_t decode_key(input logic [7:0] code);
        key_t k;
        k.valid = 1'b1;
        k.dir   = UP;
        case (code)
            KEY_UP:    k.dir = UP;
            KEY_RIGHT: k.dir = RIGHT;
            KEY_DOWN:  k.dir = DOWN;
            KEY_LEFT:  k.dir = LEFT;
            default:   k.valid = 1'b0;
        endcase
        return k;
    endfunction

    // True when the tile adjacent to (tx,ty) in direction dir lies on the map.
    function automatic logic tile_in_bounds(input logic [5:0] tx, input logic [5:0] ty,
                                            input dir_e dir, input int w_tiles,
                                            input int h_tiles);
        logic ok;
        case (dir)
            UP:      ok = (ty != 6'd0);
            RIGHT:   ok = (int'(tx) < w_tiles - 1);
            DOWN:    ok = (int'(ty) < h_tiles - 1);
            default: ok = (tx != 6'd0);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/frame_tick_detect.sv
// Brings the vsync-derived frame strobe into the Clk domain and emits a
// one-cycle tick three Clk cycles after each rising edge.
module frame_tick_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic sync_1, sync_2, sync_prev;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
            tick      <= 1'b0;
        end else begin
            sync_1    <= frame_clk;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
            tick      <= sync_2 & ~sync_prev;
        end
    end

endmodule

// File: rtl/player_move_ctrl.sv
// Tile-based character movement: turn in place, walk one 16-px tile per step,
// bump against the map edge. Everything advances once per frame tick.
module player_move_ctrl
    import pokemon_pkg::*;
#(
    parameter int MAP_W_TILES = 40,
    parameter int MAP_H_TILES = 30,
    parameter int START_TX    = 20,
    parameter int START_TY    = 15,
    parameter int TURN_FRAMES = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    output logic [1:0]  Direction,
    output logic        Character_Moving,
    output logic [9:0]  Map_X,
    output logic [9:0]  Map_Y,
    output logic        Step_Done,
    output move_state_e state_dbg
);

    localparam int CNT_MAX = (TURN_FRAMES > TILE_PX) ? TURN_FRAMES : TILE_PX;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(TILE_PX - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_FRAMES - 1);
    localparam logic [9:0] START_X = 10'(START_TX * TILE_PX);
    localparam logic [9:0] START_Y = 10'(START_TY * TILE_PX);

    logic tick;
    key_t key;

    move_state_e      state, state_next;
    dir_e             dir_q, dir_next;
    logic [9:0]       x_q, x_next, y_q, y_next;
    logic [9:0]       walk_x, walk_y;
    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic             step_q, step_next;
    logic             moving_q;

    frame_tick_detect u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    assign key = decode_key(keycode);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            dir_q    <= UP;
            x_q      <= START_X;
            y_q      <= START_Y;
            cnt_q    <= '0;
            step_q   <= 1'b0;
            moving_q <= 1'b0;
        end else begin
            state    <= state_next;
            dir_q    <= dir_next;
            x_q      <= x_next;
            y_q      <= y_next;
            cnt_q    <= cnt_next;
            step_q   <= step_next;
            moving_q <= (state_next == WALK);
        end
    end

    always_comb begin
        state_next = state;
        dir_next   = dir_q;
        x_next     = x_q;
        y_next     = y_q;
        cnt_next   = cnt_q;
        step_next  = 1'b0;
        walk_x     = x_q;
        walk_y     = y_q;

        case (dir_q)
            UP:      walk_y = y_q - 10'd1;
            RIGHT:   walk_x = x_q + 10'd1;
            DOWN:    walk_y = y_q + 10'd1;
            default: walk_x = x_q - 10'd1;
        endcase

        if (tick) begin
            case (state)
                IDLE: begin
                    if (key.valid && key.dir != dir_q) begin
                        dir_next   = key.dir;
                        cnt_next   = '0;
                        state_next = TURN;
                    end else if (key.valid &&
                                 tile_in_bounds(x_q[9:4], y_q[9:4], dir_q,
                                                MAP_W_TILES, MAP_H_TILES)) begin
                        cnt_next   = '0;
                        state_next = WALK;
                    end
                end
                TURN: begin
                    if (cnt_q == TURN_LAST) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_q + 1'b1;
                    end
                end
                WALK: begin
                    x_next = walk_x;
                    y_next = walk_y;
                    if (cnt_q == STEP_LAST) begin
                        // Tile aligned: chain straight into the next step if still held.
                        step_next = 1'b1;
                        cnt_next  = '0;
                        if (key.valid && key.dir == dir_q &&
                            tile_in_bounds(walk_x[9:4], walk_y[9:4], dir_q,
                                           MAP_W_TILES, MAP_H_TILES))
                            state_next = WALK;
                        else
                            state_next = IDLE;
                    end else begin
                        cnt_next = cnt_q + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        Direction        = dir_q;
        Character_Moving = moving_q;
        Map_X            = x_q;
        Map_Y            = y_q;
        Step_Done        = step_q;
        state_dbg        = state;
    end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Self-checking bench for player_move_ctrl: a tick-level movement model is
// compared against the DUT on every falling Clk edge, plus literal spot checks.
module tb_player_move_ctrl;

    localparam int W  = 40;
    localparam int H  = 30;
    localparam int TF = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [1:0] Direction;
    logic       Character_Moving;
    logic [9:0] Map_X, Map_Y;
    logic       Step_Done;
    logic [1:0] state_dbg;

    int errors = 0;
    int checks = 0;
    int dut_steps = 0;
    bit chk_en = 1'b0;

    // Model: mode 0 idle, 1 turning, 2 walking; remaining-tick counters.
    int m_dir, m_x, m_y, m_mode, m_turn_rem, m_px_rem;
    bit exp_step;

    player_move_ctrl dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .frame_clk        (frame_clk),
        .keycode          (keycode),
        .Direction        (Direction),
        .Character_Moving (Character_Moving),
        .Map_X            (Map_X),
        .Map_Y            (Map_Y),
        .Step_Done        (Step_Done),
        .state_dbg        (state_dbg)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int key_dir(input logic [7:0] k);
        case (k)
            8'h1A:   return 0;
            8'h07:   return 1;
            8'h16:   return 2;
            8'h04:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic bit can_step(input int x, input int y, input int d);
        int nx = x;
        int ny = y;
        case (d)
            0:       ny = y - 16;
            1:       nx = x + 16;
            2:       ny = y + 16;
            default: nx = x - 16;
        endcase
        return (nx >= 0) && (nx <= (W - 1) * 16) && (ny >= 0) && (ny <= (H - 1) * 16);
    endfunction

    task automatic model_reset();
        m_dir = 0; m_x = 320; m_y = 240; m_mode = 0;
        m_turn_rem = 0; m_px_rem = 0; exp_step = 1'b0;
    endtask

    task automatic model_tick(input logic [7:0] k);
        int kd = key_dir(k);
        case (m_mode)
            0: begin
                if (kd >= 0 && kd != m_dir) begin
                    m_dir = kd; m_mode = 1; m_turn_rem = TF;
                end else if (kd == m_dir && can_step(m_x, m_y, m_dir)) begin
                    m_mode = 2; m_px_rem = 16;
                end
            end
            1: begin
                m_turn_rem--;
                if (m_turn_rem == 0) m_mode = 0;
            end
            default: begin
                case (m_dir)
                    0:       m_y--;
                    1:       m_x++;
                    2:       m_y++;
                    default: m_x--;
                endcase
                m_px_rem--;
                if (m_px_rem == 0) begin
                    exp_step = 1'b1;
                    if (kd == m_dir && can_step(m_x, m_y, m_dir)) m_px_rem = 16;
                    else m_mode = 0;
                end
            end
        endcase
    endtask

    // One frame: strobe rises, DUT acts on the 4th Clk edge after the rise.
    task automatic do_tick(input logic [7:0] k);
        @(negedge Clk);
        keycode = k;
        frame_clk = 1'b1;
        repeat (4) @(posedge Clk);
        #1 model_tick(k);
        @(posedge Clk);
        #1 exp_step = 1'b0;
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        keycode = 8'h00;
        frame_clk = 1'b0;
        model_reset();
        #1;
        check("rst_async_x", int'(Map_X), 320);
        check("rst_async_y", int'(Map_Y), 240);
        check("rst_async_dir", int'(Direction), 0);
        check("rst_async_moving", int'(Character_Moving), 0);
        check("rst_async_step", int'(Step_Done), 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            check("dir", int'(Direction), m_dir);
            check("moving", int'(Character_Moving), int'(m_mode == 2));
            check("map_x", int'(Map_X), m_x);
            check("map_y", int'(Map_Y), m_y);
            check("step_done", int'(Step_Done), int'(exp_step));
            check("state", int'(state_dbg), m_mode);
            if (Step_Done) dut_steps++;
        end
    end

    initial begin
        model_reset();
        Reset = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        check("reset_x", int'(Map_X), 320);
        check("reset_y", int'(Map_Y), 240);
        check("reset_dir", int'(Direction), 0);
        check("reset_moving", int'(Character_Moving), 0);

        // Invalid key: nothing moves.
        repeat (10) do_tick(8'h2C);
        check("invalid_x", int'(Map_X), 320);
        check("invalid_y", int'(Map_Y), 240);
        check("invalid_state", int'(state_dbg), 0);

        // Turn right in place.
        do_tick(8'h07);
        check("turn_dir", int'(Direction), 1);
        check("turn_state", int'(state_dbg), 1);
        repeat (3) do_tick(8'h00);
        check("turn_hold_state", int'(state_dbg), 1);
        check("turn_hold_x", int'(Map_X), 320);
        do_tick(8'h00);
        check("turn_end_state", int'(state_dbg), 0);
        check("turn_end_moving", int'(Character_Moving), 0);

        // Walk up continuously.
        do_reset();
        dut_steps = 0;
        do_tick(8'h1A);
        check("walk_start_moving", int'(Character_Moving), 1);
        repeat (16) do_tick(8'h1A);
        check("walk_y_224", int'(Map_Y), 224);
        check("walk_steps_1", dut_steps, 1);
        check("walk_chain_moving", int'(Character_Moving), 1);
        repeat (3) do_tick(8'h1A);
        check("walk_y_221", int'(Map_Y), 221);
        check("walk_dir_up", int'(Direction), 0);

        // Key changes mid-step are ignored until alignment.
        do_reset();
        repeat (5) do_tick(8'h1A);
        repeat (12) do_tick(8'h16);
        check("switch_y", int'(Map_Y), 224);
        check("switch_dir", int'(Direction), 0);
        check("switch_idle", int'(state_dbg), 0);
        do_tick(8'h16);
        check("switch_turn_dir", int'(Direction), 2);
        check("switch_turn_state", int'(state_dbg), 1);

        // Reset mid-walk.
        do_reset();
        repeat (9) do_tick(8'h1A);
        check("midwalk_y", int'(Map_Y), 232);
        do_reset();

        // Walk right to the map edge, then bump.
        do_reset();
        dut_steps = 0;
        repeat (310) do_tick(8'h07);
        check("edge_x", int'(Map_X), 624);
        check("edge_state", int'(state_dbg), 0);
        check("edge_steps", dut_steps, 19);
        repeat (5) do_tick(8'h07);
        check("bump_x", int'(Map_X), 624);
        check("bump_moving", int'(Character_Moving), 0);
        check("bump_steps", dut_steps, 19);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
